// File: rtl/uart_tx.sv
// uart_tx: 8N1-style UART transmitter with a small transmit FIFO.
//
// Bytes are accepted over a valid/ready handshake into a FIFO of FIFO_DEPTH
// entries and serialised LSB first on tx_out as: start bit (0), 8 data bits,
// optional parity bit, then STOP_BITS stop bits (1). Each bit lasts
// BAUD_TICKS clock cycles.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   tx_data    in   8  byte to transmit
//   tx_valid   in   1  tx_data valid this cycle
//   tx_ready   out  1  FIFO can accept a byte this cycle (registered, !full)
//   tx_out     out  1  serial line, idles high (registered)
//   tx_busy    out  1  frame in progress or FIFO non-empty (registered)
//   frame_done out  1  one-cycle pulse on the last cycle of the final stop bit
module uart_tx #(
  parameter int BAUD_TICKS = 434,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] RELOAD   = 16'(BAUD_TICKS - 1);
  localparam logic        ODD_BIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic        TWO_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity of a byte, optionally inverted for odd parity.
  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Full when pointers differ only in their wrap bit.
  function automatic logic is_full(input logic [AW:0] w, input logic [AW:0] r);
    return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
  endfunction

  // FIFO storage and pointers
  logic [7:0]  mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic        full_s, empty_s, push_s, pop_s;
  logic [7:0]  head_s;

  // FSM and datapath state
  state_t      state_r, state_nxt_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic [2:0]  bit_idx_r, bit_idx_nxt_s;
  logic        stop_idx_r, stop_idx_nxt_s;
  logic [7:0]  shift_r, shift_nxt_s;
  logic        par_r, par_nxt_s;
  logic        cnt_zero_s, last_stop_s;

  // Registered outputs
  logic        tx_out_r, tx_out_nxt_s;
  logic        done_r, done_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        ready_r, ready_nxt_s;

  assign full_s      = is_full(wr_ptr_r, rd_ptr_r);
  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign push_s      = tx_valid && !full_s;
  assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
  assign cnt_zero_s  = (cnt_r == 16'd0);
  // With one stop bit every stop bit is the last one.
  assign last_stop_s = TWO_STOP ? stop_idx_r : 1'b1;

  assign wr_ptr_nxt_s = push_s ? (wr_ptr_r + (AW+1)'(1)) : wr_ptr_r;
  assign rd_ptr_nxt_s = pop_s  ? (rd_ptr_r + (AW+1)'(1)) : rd_ptr_r;

  // FIFO storage write and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= tx_data;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic and FIFO pop decision
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_nxt_s = START;
          pop_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_zero_s) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (cnt_zero_s && (bit_idx_r == 3'd7)) begin
          state_nxt_s = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (cnt_zero_s) begin
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      STOP: begin
        // Final stop cycle: chain straight into the next frame if queued.
        if (cnt_zero_s && last_stop_s) begin
          if (!empty_s) begin
            state_nxt_s = START;
            pop_s       = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath next values: baud counter, bit index, stop index, shift, parity
  always_comb begin
    cnt_nxt_s      = cnt_r;
    bit_idx_nxt_s  = bit_idx_r;
    stop_idx_nxt_s = stop_idx_r;
    shift_nxt_s    = shift_r;
    par_nxt_s      = par_r;

    if (state_r == IDLE) begin
      cnt_nxt_s = pop_s ? RELOAD : 16'd0;
    end else if (cnt_zero_s) begin
      cnt_nxt_s = (state_nxt_s == IDLE) ? 16'd0 : RELOAD;
    end else begin
      cnt_nxt_s = cnt_r - 16'd1;
    end

    if (pop_s) begin
      shift_nxt_s   = head_s;
      par_nxt_s     = parity_of(head_s, ODD_BIT);
      bit_idx_nxt_s = 3'd0;
    end else if ((state_r == DATA) && cnt_zero_s) begin
      // Index wraps back to 0 after bit 7, ready for the next frame.
      shift_nxt_s   = shift_r >> 1;
      bit_idx_nxt_s = bit_idx_r + 3'd1;
    end else begin
      shift_nxt_s   = shift_r;
      bit_idx_nxt_s = bit_idx_r;
    end

    if (state_r != STOP) begin
      stop_idx_nxt_s = 1'b0;
    end else if (cnt_zero_s) begin
      stop_idx_nxt_s = !last_stop_s;
    end else begin
      stop_idx_nxt_s = stop_idx_r;
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    tx_out_nxt_s = 1'b1;
    case (state_nxt_s)
      IDLE:    tx_out_nxt_s = 1'b1;
      START:   tx_out_nxt_s = 1'b0;
      DATA:    tx_out_nxt_s = shift_nxt_s[0];
      PARITY:  tx_out_nxt_s = par_r;
      STOP:    tx_out_nxt_s = 1'b1;
      default: tx_out_nxt_s = 1'b1;
    endcase
    // Raised one cycle early so the registered pulse lands on the final
    // stop cycle (counter == 0); BAUD_TICKS >= 2 guarantees the count of 1.
    done_nxt_s  = (state_r == STOP) && last_stop_s && (cnt_r == 16'd1);
    busy_nxt_s  = (state_nxt_s != IDLE) || (wr_ptr_nxt_s != rd_ptr_nxt_s);
    ready_nxt_s = !is_full(wr_ptr_nxt_s, rd_ptr_nxt_s);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= 16'd0;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      shift_r    <= 8'd0;
      par_r      <= 1'b0;
      tx_out_r   <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      cnt_r      <= cnt_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      stop_idx_r <= stop_idx_nxt_s;
      shift_r    <= shift_nxt_s;
      par_r      <= par_nxt_s;
      tx_out_r   <= tx_out_nxt_s;
      done_r     <= done_nxt_s;
      busy_r     <= busy_nxt_s;
      ready_r    <= ready_nxt_s;
    end
  end

  assign tx_out     = tx_out_r;
  assign frame_done = done_r;
  assign tx_busy    = busy_r;
  assign tx_ready   = ready_r;

endmodule
